// File: rtl/xbee_frame_parser_pkg.sv
// xbee_pkg: shared constants and the parser state type for the XBee API
// frame parser (xbee_frame_parser, xbee_frame_buf).
// Optional feature macro used by the parser: XBEE_PARSER_ESCAPE_EN.
package xbee_pkg;

  localparam logic [7:0] START_DELIM = 8'h7E;
  localparam logic [7:0] ESC_BYTE    = 8'h7D;
  localparam logic [7:0] ESC_XOR     = 8'h20;
  localparam logic [7:0] CKSUM_GOOD  = 8'hFF;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN_MSB,
    ST_LEN_LSB,
    ST_DATA,
    ST_CKSUM,
    ST_HOLD
  } parser_state_t;

  // 8-bit wrapping checksum accumulation.
  function automatic logic [7:0] cksumAdd(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/xbee_frame_parser_if.sv
// xbee_frame_parser_if: bundles the UART byte input, the host read port with
// its valid/ack handshake, and the error pulses of xbee_frame_parser.
//   master : UART receiver + host side (drives rx_*, rd_addr, frame_ack)
//   slave  : parser side (drives frame_*, rd_data, *_err)
interface xbee_frame_parser_if #(
  parameter int ADDR_W = 5
);
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              frame_valid;
  logic [ADDR_W:0]   frame_len;
  logic [7:0]        frame_type;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              frame_ack;
  logic              cksum_err;
  logic              len_err;
  logic              timeout_err;
  logic              overrun_err;

  modport master (
    output rx_data, rx_ready, rd_addr, frame_ack,
    input  frame_valid, frame_len, frame_type, rd_data,
           cksum_err, len_err, timeout_err, overrun_err
  );

  modport slave (
    input  rx_data, rx_ready, rd_addr, frame_ack,
    output frame_valid, frame_len, frame_type, rd_data,
           cksum_err, len_err, timeout_err, overrun_err
  );
endinterface

// File: rtl/xbee_frame_buf.sv
// xbee_frame_buf: 2**ADDR_W x 8 simple dual-port frame buffer.
//   clk, reset : clock, async active-high reset (read register only)
//   wrEn/wrAddr/wrData : write port from the parser
//   rdAddr/rdData      : registered read port (1-cycle latency)
module xbee_frame_buf #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [7:0]        wrData,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [7:0]        rdData
);

  logic [7:0] mem [2**ADDR_W];

  // Storage carries no reset so it can map onto block/distributed RAM.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdData <= '0;
    else       rdData <= mem[rdAddr];
  end

endmodule

// File: rtl/xbee_frame_parser.sv
// xbee_frame_parser: XBee API frame parser downstream of a UART receiver.
// Hunts for 0x7E, captures length / frame data / checksum, stores the frame
// data in xbee_frame_buf and holds a checksum-good frame for the host until
// frame_ack.
//   clk, reset : clock, async active-high reset
//   bus        : xbee_frame_parser_if.slave (rx byte in, host read port,
//                valid/ack handshake, single-cycle error pulses)
// Parameters: MAX_LEN (largest frame-data length), ADDR_W (buffer address
// width, 2**ADDR_W >= MAX_LEN), TIMEOUT_CYCLES (inter-byte timeout).
// Build option: define XBEE_PARSER_ESCAPE_EN for API mode 2 escaping.
module xbee_frame_parser #(
  parameter int MAX_LEN        = 32,
  parameter int ADDR_W         = 5,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input logic clk,
  input logic reset,
  xbee_frame_parser_if.slave bus
);
  import xbee_pkg::*;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  if (2**ADDR_W < MAX_LEN) begin : gBadCfg
    $error("xbee_frame_parser: 2**ADDR_W must be >= MAX_LEN");
  end

  parser_state_t     state, stateNxt;
  logic              rdyQ, accept;
  logic [7:0]        lenMsb, lenMsbNxt;
  logic [ADDR_W:0]   len, lenNxt, idx, idxNxt, idxInc;
  logic [7:0]        sum, sumNxt, sumAdd;
  logic              esc, escNxt;
  logic [7:0]        typeQ, typeNxt;
  logic [7:0]        frameTypeQ;
  logic [ADDR_W:0]   frameLenQ;
  logic [TW-1:0]     tmoCnt;
  logic              commit;
  logic              cksumErrNxt, lenErrNxt, tmoErrNxt, ovrErrNxt;
  logic              cksumErrQ, lenErrQ, tmoErrQ, ovrErrQ;
  logic              wrEn;
  logic [7:0]        byteEff;
  logic [15:0]       lenVal;
  logic              inFrame, tmoHit, escPrefix, restart;

  // Byte strobe: rising edge of the rx_ready level.
  assign accept  = bus.rx_ready & ~rdyQ;
  assign inFrame = (state != ST_HUNT) && (state != ST_HOLD);
  assign byteEff = esc ? (bus.rx_data ^ ESC_XOR) : bus.rx_data;
  assign lenVal  = {lenMsb, byteEff};
  assign idxInc  = idx + 1'b1;
  assign sumAdd  = cksumAdd(sum, byteEff);
  // An accept on the expiry cycle counts as activity, so it wins.
  assign tmoHit  = inFrame && !accept && (tmoCnt == TMO_LAST);

`ifdef XBEE_PARSER_ESCAPE_EN
  assign escPrefix = accept && inFrame && !esc && (bus.rx_data == ESC_BYTE);
  assign restart   = accept && inFrame && !esc && (bus.rx_data == START_DELIM);
`else
  assign escPrefix = 1'b0;
  assign restart   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdyQ <= 1'b0;
    else       rdyQ <= bus.rx_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                                tmoCnt <= '0;
    else if (accept || state == ST_HUNT || state == ST_HOLD)  tmoCnt <= '0;
    else if (tmoCnt != TMO_LAST)                              tmoCnt <= tmoCnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_HUNT;
      lenMsb     <= '0;
      len        <= '0;
      idx        <= '0;
      sum        <= '0;
      esc        <= 1'b0;
      typeQ      <= '0;
      frameLenQ  <= '0;
      frameTypeQ <= '0;
      cksumErrQ  <= 1'b0;
      lenErrQ    <= 1'b0;
      tmoErrQ    <= 1'b0;
      ovrErrQ    <= 1'b0;
    end else begin
      state     <= stateNxt;
      lenMsb    <= lenMsbNxt;
      len       <= lenNxt;
      idx       <= idxNxt;
      sum       <= sumNxt;
      esc       <= escNxt;
      typeQ     <= typeNxt;
      cksumErrQ <= cksumErrNxt;
      lenErrQ   <= lenErrNxt;
      tmoErrQ   <= tmoErrNxt;
      ovrErrQ   <= ovrErrNxt;
      // Host-visible length/type only change when a new frame is committed.
      if (commit) begin
        frameLenQ  <= len;
        frameTypeQ <= typeQ;
      end
    end
  end

  always_comb begin
    stateNxt    = state;
    lenMsbNxt   = lenMsb;
    lenNxt      = len;
    idxNxt      = idx;
    sumNxt      = sum;
    escNxt      = esc;
    typeNxt     = typeQ;
    wrEn        = 1'b0;
    commit      = 1'b0;
    cksumErrNxt = 1'b0;
    lenErrNxt   = 1'b0;
    tmoErrNxt   = 1'b0;
    ovrErrNxt   = 1'b0;

    unique case (state)
      ST_HUNT: begin
        escNxt = 1'b0;
        if (accept && bus.rx_data == START_DELIM) stateNxt = ST_LEN_MSB;
      end

      ST_HOLD: begin
        escNxt = 1'b0;
        // Ack wins over a coincident byte, which is then judged as in HUNT.
        if (bus.frame_ack) begin
          if (accept && bus.rx_data == START_DELIM) stateNxt = ST_LEN_MSB;
          else                                      stateNxt = ST_HUNT;
        end else if (accept) begin
          ovrErrNxt = 1'b1;
        end
      end

      default: begin
        if (tmoHit) begin
          tmoErrNxt = 1'b1;
          escNxt    = 1'b0;
          stateNxt  = ST_HUNT;
        end else if (restart) begin
          escNxt   = 1'b0;
          stateNxt = ST_LEN_MSB;
        end else if (escPrefix) begin
          escNxt = 1'b1;
        end else if (accept) begin
          escNxt = 1'b0;
          case (state)
            ST_LEN_MSB: begin
              lenMsbNxt = byteEff;
              stateNxt  = ST_LEN_LSB;
            end
            ST_LEN_LSB: begin
              if (lenVal == 16'd0 || lenVal > 16'(MAX_LEN)) begin
                lenErrNxt = 1'b1;
                stateNxt  = ST_HUNT;
              end else begin
                lenNxt   = lenVal[ADDR_W:0];
                idxNxt   = '0;
                sumNxt   = '0;
                stateNxt = ST_DATA;
              end
            end
            ST_DATA: begin
              wrEn   = 1'b1;
              sumNxt = sumAdd;
              idxNxt = idxInc;
              if (idx == '0) typeNxt = byteEff;
              if (idxInc == len) stateNxt = ST_CKSUM;
            end
            ST_CKSUM: begin
              if (sumAdd == CKSUM_GOOD) begin
                commit   = 1'b1;
                stateNxt = ST_HOLD;
              end else begin
                cksumErrNxt = 1'b1;
                stateNxt    = ST_HUNT;
              end
            end
            default: stateNxt = ST_HUNT;
          endcase
        end
      end
    endcase
  end

  xbee_frame_buf #(
    .ADDR_W(ADDR_W)
  ) uBuf (
    .clk    (clk),
    .reset  (reset),
    .wrEn   (wrEn),
    .wrAddr (idx[ADDR_W-1:0]),
    .wrData (byteEff),
    .rdAddr (bus.rd_addr),
    .rdData (bus.rd_data)
  );

  assign bus.frame_valid = (state == ST_HOLD);
  assign bus.frame_len   = frameLenQ;
  assign bus.frame_type  = frameTypeQ;
  assign bus.cksum_err   = cksumErrQ;
  assign bus.len_err     = lenErrQ;
  assign bus.timeout_err = tmoErrQ;
  assign bus.overrun_err = ovrErrQ;

endmodule

// File: tb/tb_xbee_frame_parser.sv
// tb_xbee_frame_parser: directed + randomized self-checking bench for
// xbee_frame_parser. Frames are described as byte lists; expected validity
// and read-back contents come from the checksum rule applied to those lists.
// Honours XBEE_PARSER_ESCAPE_EN (escapes 7D/7E on the wire when defined).
module tb_xbee_frame_parser;

  localparam int MAX_LEN = 32;
  localparam int ADDR_W  = 5;
  localparam int TMO     = 200;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  xbee_frame_parser_if #(.ADDR_W(ADDR_W)) bus ();

  xbee_frame_parser #(
    .MAX_LEN        (MAX_LEN),
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int nAsserts = 0;
  int nFails   = 0;
  int ckCnt = 0, lenCnt = 0, tmoCnt = 0, ovrCnt = 0;

  always @(negedge clk) begin
    if (bus.cksum_err   === 1'b1) ckCnt++;
    if (bus.len_err     === 1'b1) lenCnt++;
    if (bus.timeout_err === 1'b1) tmoCnt++;
    if (bus.overrun_err === 1'b1) ovrCnt++;
  end

  logic [7:0] dq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One byte on the UART handshake; ends at the negedge after the accept edge.
  task automatic sendByte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
  endtask

  task automatic gap(input int maxGap);
    repeat ($urandom_range(0, maxGap)) @(negedge clk);
  endtask

  // Frame-body byte, escaped on the wire in API mode 2.
  task automatic sendWire(input logic [7:0] b);
`ifdef XBEE_PARSER_ESCAPE_EN
    if (b == 8'h7E || b == 8'h7D) begin
      sendByte(8'h7D);
      sendByte(b ^ 8'h20);
    end else sendByte(b);
`else
    sendByte(b);
`endif
  endtask

  task automatic sendFrame(input logic [7:0] ck, input int maxGap);
    sendByte(8'h7E);                       gap(maxGap);
    sendWire(8'h00);                       gap(maxGap);
    sendWire(8'(dq.size()));               gap(maxGap);
    foreach (dq[i]) begin sendWire(dq[i]); gap(maxGap); end
    sendWire(ck);
  endtask

  function automatic logic [7:0] goodCk();
    int s = 0;
    foreach (dq[i]) s += dq[i];
    return 8'(255 - (s % 256));
  endfunction

  function automatic bit ckOk(input logic [7:0] ck);
    int s = ck;
    foreach (dq[i]) s += dq[i];
    return (s % 256) == 255;
  endfunction

  task automatic readCheck(input int a, input logic [7:0] exp, input string tag);
    @(negedge clk);
    bus.rd_addr = ADDR_W'(a);
    @(negedge clk);
    check(tag, bus.rd_data, exp);
  endtask

  task automatic verifyHeld(input string tag);
    check({tag, ".valid"}, bus.frame_valid, 1);
    check({tag, ".len"},   bus.frame_len, dq.size());
    check({tag, ".type"},  bus.frame_type, dq[0]);
    foreach (dq[i]) readCheck(i, dq[i], $sformatf("%s.rd%0d", tag, i));
  endtask

  task automatic ackFrame(input string tag);
    @(negedge clk);
    bus.frame_ack = 1'b1;
    @(negedge clk);
    bus.frame_ack = 1'b0;
    check({tag, ".ackclr"}, bus.frame_valid, 0);
  endtask

  initial begin
    int c0, n;
    logic [7:0] ck;
    bus.rx_data = '0; bus.rx_ready = 1'b0; bus.rd_addr = '0; bus.frame_ack = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.valid", bus.frame_valid, 0);
    check("rst.len",   bus.frame_len, 0);
    check("rst.type",  bus.frame_type, 0);
    check("rst.rd",    bus.rd_data, 0);
    check("rst.errs",  {bus.cksum_err, bus.len_err, bus.timeout_err, bus.overrun_err}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Reference frame, back-to-back bytes: valid exactly one cycle after the checksum accept.
    dq = '{8'h08, 8'h01, 8'h4D, 8'h59};
    check("ref.ck", goodCk(), 8'h50);
    sendFrame(8'h50, 0);
    verifyHeld("ref");
    ackFrame("ref");

    // Bad checksum, then a good frame.
    c0 = ckCnt;
    sendFrame(8'h51, 1);
    repeat (2) @(negedge clk);
    check("badck.pulse", ckCnt - c0, 1);
    check("badck.valid", bus.frame_valid, 0);
    sendFrame(8'h50, 1);
    verifyHeld("afterbad");
    ackFrame("afterbad");

    // Length 0 and MAX_LEN+1.
    c0 = lenCnt;
    sendByte(8'h7E); sendByte(8'h00); sendByte(8'h00);
    sendByte(8'h7E); sendByte(8'h00); sendByte(8'(MAX_LEN + 1));
    repeat (2) @(negedge clk);
    check("lenerr.pulses", lenCnt - c0, 2);
    check("lenerr.valid",  bus.frame_valid, 0);

    // Inter-byte timeout mid-frame.
    c0 = tmoCnt;
    sendByte(8'h7E); sendByte(8'h00); sendByte(8'h04); sendByte(8'h08);
    repeat (TMO / 2) @(negedge clk);
    check("tmo.early", tmoCnt - c0, 0);
    repeat (TMO / 2 + 20) @(negedge clk);
    check("tmo.pulse", tmoCnt - c0, 1);
    sendFrame(8'h50, 2);
    verifyHeld("aftertmo");

    // Overrun while held: bytes dropped, buffer unchanged.
    c0 = ovrCnt;
    for (int i = 0; i < 3; i++) begin sendByte(8'($urandom)); gap(2); end
    repeat (2) @(negedge clk);
    check("ovr.pulses", ovrCnt - c0, 3);
    verifyHeld("ovr");

    // Ack coincident with a 0x7E accept: the 7E starts a new frame.
    c0 = ovrCnt;
    @(negedge clk);
    bus.rx_data = 8'h7E; bus.rx_ready = 1'b1; bus.frame_ack = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0; bus.frame_ack = 1'b0;
    check("ackacc.valid", bus.frame_valid, 0);
    dq = '{8'hAA};
    sendByte(8'h00); sendByte(8'h01); sendByte(8'hAA); sendByte(8'h55);
    check("ackacc.ovr", ovrCnt - c0, 0);
    verifyHeld("ackacc");
    ackFrame("ackacc");

    // Randomized frames against the checksum rule, including length boundaries.
    for (int f = 0; f < 24; f++) begin
      n = (f == 0) ? 1 : (f == 1) ? MAX_LEN : $urandom_range(1, MAX_LEN);
      dq.delete();
      for (int i = 0; i < n; i++) dq.push_back(8'($urandom));
      ck = goodCk();
      if ($urandom_range(0, 3) == 0) ck = ck ^ 8'($urandom_range(1, 255));
      c0 = ckCnt;
      sendFrame(ck, 3);
      repeat (2) @(negedge clk);
      if (ckOk(ck)) begin
        check($sformatf("rnd%0d.noerr", f), ckCnt - c0, 0);
        verifyHeld($sformatf("rnd%0d", f));
        ackFrame($sformatf("rnd%0d", f));
      end else begin
        check($sformatf("rnd%0d.ckerr", f), ckCnt - c0, 1);
        check($sformatf("rnd%0d.valid", f), bus.frame_valid, 0);
      end
    end

    // Escaping behaviour (or its absence).
    c0 = ckCnt;
    sendByte(8'h7E); sendByte(8'h00); sendByte(8'h02);
    sendByte(8'h7D); sendByte(8'h31); sendByte(8'h7D); sendByte(8'h5E); sendByte(8'hAF);
    repeat (2) @(negedge clk);
    check("esc.badck", ckCnt - c0, 1);
    check("esc.valid", bus.frame_valid, 0);
`ifdef XBEE_PARSER_ESCAPE_EN
    sendByte(8'h7E); sendByte(8'h00); sendByte(8'h02);
    sendByte(8'h7D); sendByte(8'h31); sendByte(8'h7D); sendByte(8'h5E); sendByte(8'h70);
    dq = '{8'h11, 8'h7E};
    verifyHeld("escgood");
    ackFrame("escgood");
    // Unescaped 7E mid-frame restarts silently.
    c0 = ckCnt + lenCnt;
    sendByte(8'h7E); sendByte(8'h00); sendByte(8'h05); sendByte(8'h11); sendByte(8'h22);
    dq = '{8'hAA};
    sendFrame(8'h55, 1);
    check("restart.noerr", ckCnt + lenCnt - c0, 0);
    verifyHeld("restart");
    ackFrame("restart");
`endif

    // Reset mid-frame discards the partial frame.
    sendByte(8'h7E); sendByte(8'h00); sendByte(8'h05); sendByte(8'h11);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst.valid", bus.frame_valid, 0);
    check("midrst.len",   bus.frame_len, 0);
    check("midrst.type",  bus.frame_type, 0);
    reset = 1'b0;
    @(negedge clk);
    dq = '{8'hC3, 8'h10, 8'h20};
    sendFrame(goodCk(), 1);
    verifyHeld("midrst");
    ackFrame("midrst");

    repeat (3) @(negedge clk);
    check("tot.tmo", tmoCnt, 1);
    check("tot.len", lenCnt, 2);
    check("tot.ovr", ovrCnt, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
